// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg: shared types and defaults for the PE sequencer.
package pe_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RD,
        S_CV,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_e;

    localparam int          CLR_CYCLES_DEF = 2;
    localparam int          TIMEOUT_DEF    = 64;
    localparam logic [31:0] FP32_ZERO      = 32'h0000_0000;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if: input word stream plus the PE-facing bus.
// master = sequencer side, slave = word source / PE side.
interface pe_seq_ctrl_if #(
    parameter int L_RAM_SIZE = 6
);
    logic                  s_tvalid;
    logic                  s_tready;
    logic [31:0]           s_tdata;
    logic                  pe_aresetn;
    logic [31:0]           pe_din;
    logic [L_RAM_SIZE-1:0] pe_addr;
    logic                  pe_we;
    logic [31:0]           pe_ain;
    logic                  pe_valid;
    logic                  pe_dvalid;
    logic [31:0]           pe_dout;

    modport master (
        input  s_tvalid, s_tdata, pe_dvalid, pe_dout,
        output s_tready, pe_aresetn, pe_din, pe_addr, pe_we, pe_ain, pe_valid
    );

    modport slave (
        output s_tvalid, s_tdata, pe_dvalid, pe_dout,
        input  s_tready, pe_aresetn, pe_din, pe_addr, pe_we, pe_ain, pe_valid
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: loads B into the PE RAM, clears the accumulator and streams
// A one element at a time, waiting for each FMA result before the next issue.
// Optional WAIT watchdog: define PE_SEQ_TIMEOUT_EN.
module pe_seq_ctrl
    import pe_seq_pkg::*;
#(
    parameter int L_RAM_SIZE = 6,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic                load,
    input  logic [L_RAM_SIZE:0] len,
    output logic                busy,
    output logic                done,
    output logic [31:0]         result,
    output logic                err,
    pe_seq_ctrl_if.master       bus
);
    localparam int LW = L_RAM_SIZE + 1;
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [LW-1:0] MAX_LEN = {1'b1, {L_RAM_SIZE{1'b0}}};

    // Elaboration-time sanity checks on the configuration.
    if (CLR_CYCLES < 2) begin : g_bad_clr
        $error("CLR_CYCLES must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_tmo
        $error("TIMEOUT must be at least 1");
    end

    state_e            state_q, state_d;
    logic [LW-1:0]     idx_q, idx_d, len_q, len_d;
    logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [31:0]       result_q, result_d;
    logic              s_tready_q, s_tready_d, pe_aresetn_q, pe_aresetn_d;
    logic [31:0]       pe_din_q, pe_din_d, pe_ain_q, pe_ain_d;
    logic [L_RAM_SIZE-1:0] pe_addr_q, pe_addr_d;
    logic              pe_we_q, pe_we_d, pe_valid_q, pe_valid_d;
    logic              hs;
`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              abort_q, abort_d, err_q, err_d;
`endif

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        clr_cnt_d  = clr_cnt_q;
        result_d   = result_q;
        pe_din_d   = pe_din_q;
        pe_ain_d   = pe_ain_q;
        pe_addr_d  = pe_addr_q;
        pe_we_d    = 1'b0;
        hs         = bus.s_tvalid && s_tready_q;
`ifdef PE_SEQ_TIMEOUT_EN
        tmo_d      = tmo_q;
        abort_d    = abort_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                idx_d     = '0;
                clr_cnt_d = '0;
                len_d     = (len > MAX_LEN) ? MAX_LEN : len;
`ifdef PE_SEQ_TIMEOUT_EN
                err_d     = 1'b0;
                abort_d   = 1'b0;
`endif
                if (len_d == '0) begin
                    state_d = S_FIN;
                    if (!load) result_d = FP32_ZERO;
                end else begin
                    state_d = load ? S_LOAD : S_CLR;
                end
            end
            S_LOAD: if (hs) begin
                pe_we_d   = 1'b1;
                pe_addr_d = idx_q[L_RAM_SIZE-1:0];
                pe_din_d  = bus.s_tdata;
                idx_d     = idx_q + LW'(1);
                if (idx_d == len_q) state_d = S_FIN;
            end
            S_CLR: begin
                if (clr_cnt_q == CW'(CLR_CYCLES - 1)) begin
`ifdef PE_SEQ_TIMEOUT_EN
                    state_d = abort_q ? S_FIN : S_RD;
`else
                    state_d = S_RD;
`endif
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            S_RD: if (hs) begin
                pe_ain_d = bus.s_tdata;
                state_d  = S_CV;
            end
            S_CV:    state_d = S_ISSUE;
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef PE_SEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                if (bus.pe_dvalid) begin
                    idx_d = idx_q + LW'(1);
                    if (idx_d == len_q) begin
                        result_d = bus.pe_dout;
                        state_d  = S_FIN;
                    end else begin
                        state_d = S_RD;
                    end
                end
`ifdef PE_SEQ_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    abort_d   = 1'b1;
                    clr_cnt_d = '0;
                    state_d   = S_CLR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Fetch address tracks the element about to be read.
        if (state_d == S_RD) pe_addr_d = idx_d[L_RAM_SIZE-1:0];

        s_tready_d   = (state_d == S_LOAD) || (state_d == S_RD);
        busy_d       = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d       = (state_d == S_FIN);
        pe_aresetn_d = (state_d != S_CLR);
        pe_valid_d   = (state_d == S_ISSUE);
    end

    // State and output registers; synchronous reset aborts to IDLE.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            clr_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= FP32_ZERO;
            s_tready_q   <= 1'b0;
            pe_aresetn_q <= 1'b0;
            pe_din_q     <= '0;
            pe_ain_q     <= '0;
            pe_addr_q    <= '0;
            pe_we_q      <= 1'b0;
            pe_valid_q   <= 1'b0;
`ifdef PE_SEQ_TIMEOUT_EN
            tmo_q        <= '0;
            abort_q      <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            clr_cnt_q    <= clr_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            s_tready_q   <= s_tready_d;
            pe_aresetn_q <= pe_aresetn_d;
            pe_din_q     <= pe_din_d;
            pe_ain_q     <= pe_ain_d;
            pe_addr_q    <= pe_addr_d;
            pe_we_q      <= pe_we_d;
            pe_valid_q   <= pe_valid_d;
`ifdef PE_SEQ_TIMEOUT_EN
            tmo_q        <= tmo_d;
            abort_q      <= abort_d;
            err_q        <= err_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;
`ifdef PE_SEQ_TIMEOUT_EN
    assign err            = err_q;
`else
    assign err            = 1'b0;
`endif
    assign bus.s_tready   = s_tready_q;
    assign bus.pe_aresetn = pe_aresetn_q;
    assign bus.pe_din     = pe_din_q;
    assign bus.pe_addr    = pe_addr_q;
    assign bus.pe_we      = pe_we_q;
    assign bus.pe_ain     = pe_ain_q;
    assign bus.pe_valid   = pe_valid_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed stimulus with a scoreboard monitor and a
// behavioural PE model (64-entry RAM, 5-cycle FMA, accumulate on dvalid).
// Build with PE_SEQ_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_pe_seq_ctrl;
    import pe_seq_pkg::*;

    localparam int L = 6;
    localparam logic [31:0] B2  = 32'h0040_0000;  // fp16 2.0 in bits [23:8]
    localparam logic [31:0] A1  = 32'h003C_0000;  // fp16 1.0 in bits [23:8]
    localparam logic [31:0] R8  = 32'h4100_0000;  // fp32 8.0

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        load = 1'b0;
    logic [L:0]  len = '0;
    logic        busy, done, err;
    logic [31:0] result;

    pe_seq_ctrl_if #(.L_RAM_SIZE(L)) bus ();

    pe_seq_ctrl #(.L_RAM_SIZE(L), .CLR_CYCLES(2), .TIMEOUT(64)) dut (
        .aclk(aclk), .areset(areset), .start(start), .load(load), .len(len),
        .busy(busy), .done(done), .result(result), .err(err), .bus(bus)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    typedef struct packed { logic [31:0] res; logic err; } exp_t;
    typedef struct packed { logic [L-1:0] a; logic [31:0] d; } wr_t;
    exp_t sbq[$];
    wr_t  wq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural PE ----------------
    logic [31:0] ram [64];
    logic [3:0]  vp;
    real         acc, prod;
    logic        hang = 1'b0;

    function automatic real f16(input logic [15:0] h);
        int  e;
        real v;
        e = int'(h[14:10]);
        if (e == 0) v = real'(h[9:0]) / 16777216.0;
        else begin
            v = 1.0 + real'(h[9:0]) / 1024.0;
            for (int k = e; k > 15; k--) v = v * 2.0;
            for (int k = e; k < 15; k++) v = v / 2.0;
        end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic        s;
        int          e;
        logic [22:0] m;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        if (s) r = -r;
        e = 127;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        m = 23'($rtoi((r - 1.0) * 8388608.0));
        return {s, 8'(e), m};
    endfunction

    always @(posedge aclk) begin
        if (bus.pe_we) ram[bus.pe_addr] <= bus.pe_din;
        if (!bus.pe_aresetn) begin
            vp            <= '0;
            acc           <= 0.0;
            prod          <= 0.0;
            bus.pe_dvalid <= 1'b0;
            bus.pe_dout   <= '0;
        end else begin
            vp <= {vp[2:0], bus.pe_valid};
            if (bus.pe_valid) prod <= f16(ram[bus.pe_addr][23:8]) * f16(bus.pe_ain[23:8]);
            bus.pe_dvalid <= vp[3] & ~hang;
            if (vp[3] && !hang) begin
                acc         <= acc + prod;
                bus.pe_dout <= r2f(acc + prod);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int cyc = 0, last_hs = -100, vcnt = 0, act = 0, clr_run = 0;

    initial forever begin
        @(negedge aclk);
        cyc++;
        if (bus.s_tvalid && bus.s_tready) last_hs = cyc;
        if (bus.pe_we || bus.pe_valid || (!bus.pe_aresetn && !areset)) act++;
        if (bus.pe_valid) begin
            vcnt++;
            chk("valid_align", 32'(cyc - last_hs), 32'd2);
            chk("valid_in_wait", 32'(vp != 0 || bus.pe_dvalid), 32'd0);
        end
        if (bus.pe_we) begin
            if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr", 32'(bus.pe_addr), 32'(w.a));
                chk("wr_data", bus.pe_din, w.d);
            end
        end
        if (areset) clr_run = 0;
        else if (busy && !bus.pe_aresetn) clr_run++;
        else if (clr_run != 0) begin
            chk("clr_len", 32'(clr_run), 32'd2);
            clr_run = 0;
        end
        if (done) begin
            if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", result, e.res);
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cmd(input logic ld, input logic [L:0] n);
        @(posedge aclk); #1;
        start = 1'b1; load = ld; len = n;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input int gap, input logic wr, input logic [L-1:0] a);
        bit ok = 0;
        repeat (gap) begin @(posedge aclk); #1; end
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge aclk);
            if (bus.s_tready) begin ok = 1; break; end
        end
        if (!ok) chk("hs_timeout", 32'd1, 32'd0);
        else if (wr) wq.push_back({a, d});
        @(posedge aclk); #1;
        bus.s_tvalid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge aclk);
            if (done) begin n = k; break; end
        end
        if (n == 0) chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic compute4(input int g0, input int g1, input int g2, input int g3);
        int v0, n;
        v0 = vcnt;
        sbq.push_back({R8, 1'b0});
        cmd(1'b0, 7'd4);
        push(A1, g0, 1'b0, '0);
        push(A1, g1, 1'b0, '0);
        push(A1, g2, 1'b0, '0);
        push(A1, g3, 1'b0, '0);
        wait_done(n);
        chk("valid_count", 32'(vcnt - v0), 32'd4);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, a0, v0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_tready", 32'(bus.s_tready), 32'd0);
        chk("rst_pe_aresetn", 32'(bus.pe_aresetn), 32'd0);
        chk("rst_pe_valid", 32'(bus.pe_valid), 32'd0);
        chk("rst_pe_we", 32'(bus.pe_we), 32'd0);
        @(posedge aclk); #1 areset = 1'b0;
        repeat (2) @(posedge aclk);

        // Load B = four fp16 2.0 words.
        sbq.push_back({32'h0, 1'b0});
        cmd(1'b1, 7'd4);
        for (int i = 0; i < 4; i++) push(B2, 0, 1'b1, L'(i));
        wait_done(n);

        // Compute, back-to-back repeat, then gapped stream.
        compute4(0, 0, 0, 0);
        compute4(0, 0, 0, 0);
        compute4(3, 0, 7, 5);

        // len=0 compute: done next cycle, result cleared, PE untouched.
        a0 = act;
        sbq.push_back({32'h0, 1'b0});
        cmd(1'b0, 7'd0);
        @(negedge aclk);
        chk("len0_done", 32'(done), 32'd1);
        repeat (3) @(posedge aclk);
        chk("len0_no_pe", 32'(act - a0), 32'd0);

        // Oversized load saturates to 64 writes.
        sbq.push_back({32'h0, 1'b0});
        cmd(1'b1, 7'd127);
        for (int i = 0; i < 64; i++) push(B2, 0, 1'b1, L'(i));
        wait_done(n);
        chk("sat_writes_left", 32'(wq.size()), 32'd0);
        @(negedge aclk);
        chk("sat_tready_low", 32'(bus.s_tready), 32'd0);

        // Abort in WAIT of element 2 (index 1).
        v0 = vcnt;
        cmd(1'b0, 7'd4);
        push(A1, 0, 1'b0, '0);
        push(A1, 0, 1'b0, '0);
        for (int k = 0; k < 50 && vcnt < v0 + 2; k++) @(negedge aclk);
        chk("abort_reach_issue", 32'(vcnt - v0), 32'd2);
        @(posedge aclk); #1 areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pe_aresetn", 32'(bus.pe_aresetn), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge aclk); #1 areset = 1'b0;
        repeat (8) @(posedge aclk);
        compute4(1, 0, 2, 0);

`ifdef PE_SEQ_TIMEOUT_EN
        // PE never answers: 64 WAIT cycles, 2 CLR cycles, then FIN.
        hang = 1'b1;
        sbq.push_back({R8, 1'b1});
        cmd(1'b0, 7'd1);
        push(A1, 0, 1'b0, '0);
        wait_done(n);
        chk("tmo_latency", 32'(n), 32'd69);
        @(negedge aclk);
        chk("tmo_err_sticky", 32'(err), 32'd1);
        hang = 1'b0;
        sbq.push_back({R8, 1'b0});
        cmd(1'b1, 7'd1);
        @(negedge aclk);
        chk("tmo_err_cleared", 32'(err), 32'd0);
        push(B2, 0, 1'b1, '0);
        wait_done(n);
`endif

        repeat (5) @(posedge aclk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
- Sequencer directly upstream of the PE (my_pe).
- Loads the PE local RAM with B-vector words, clears the PE accumulator, and streams A-vector words one element at a time.
- Meets the PE's register/fetch alignment and waits for each FMA result before issuing the next, because the accumulator feedback updates only on dvalid.
- Captures the final dot-product (fp32) and reports done.

Parameters:
- L_RAM_SIZE, 6, PE RAM address width; max vector length 2**L_RAM_SIZE.
- CLR_CYCLES, 2, cycles pe_aresetn is held low to clear the PE/FMA (minimum 2).
- TIMEOUT, 64, max cycles waiting for pe_dvalid. Used only with PE_SEQ_TIMEOUT_EN.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; ignored while busy.
- load  in  1  sampled with start: 1 = load B into RAM, 0 = compute dot product.
- len  in  L_RAM_SIZE+1  element count, sampled with start.
- s_tvalid  in  1  input word stream valid.
- s_tready  out  1  input word stream ready.
- s_tdata  in  32  big-endian packed fp16 word, passed to the PE unmodified.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- result  out  32  fp32 dot product; holds until the next compute completes.
- err  out  1  timeout flag (feature only; tied 0 otherwise).
- pe_aresetn  out  1  PE reset, active-low.
- pe_din  out  32  PE RAM write data.
- pe_addr  out  L_RAM_SIZE  PE RAM address.
- pe_we  out  1  PE RAM write enable.
- pe_ain  out  32  PE port A data.
- pe_valid  out  1  PE issue strobe.
- pe_dvalid  in  1  PE result valid.
- pe_dout  in  32  PE result.

Behaviour:
- Reset: state IDLE; pe_aresetn=0 while areset is high. All other outputs 0 (result=0, s_tready=0, pe_*=0). areset mid-operation aborts to IDLE immediately; no done pulse.
- All outputs are registered.
- len sizing:
  - len > 2**L_RAM_SIZE saturates to 2**L_RAM_SIZE.
  - len=0: done pulses the cycle after start; the PE is untouched. Compute with len=0 sets result=0.
- FSM states: IDLE, LOAD, CLR, RD, CV, ISSUE, WAIT, FIN.
- IDLE: on start, go to LOAD if load=1, else CLR. The element index idx is reset to 0.
- LOAD:
  - s_tready=1.
  - Each handshake registers pe_we=1, pe_addr=idx, pe_din=s_tdata; the write lands one cycle after the handshake.
  - idx increments per handshake; after the len-th handshake go to FIN.
  - s_tready drops in the cycle after the final handshake.
- CLR: pe_aresetn=0 for exactly CLR_CYCLES cycles, then go to RD.
- RD (fetch):
  - pe_addr=idx, pe_we=0, s_tready=1.
  - Stall in RD until s_tvalid; on handshake latch the word into the pe_ain holding register and go to CV.
  - The B word registers inside the PE at this edge.
- CV: pe_ain held. The PE registers its conversions this edge. Go to ISSUE.
- ISSUE: pe_valid=1 for exactly one cycle; pe_ain and pe_addr held. Go to WAIT.
- WAIT:
  - pe_valid=0; wait for pe_dvalid.
  - On pe_dvalid: idx++. If idx==len, capture result<=pe_dout and go to FIN; else go to RD.
- FIN: done=1 for one cycle, busy drops the same cycle, go to IDLE.
- pe_dvalid outside WAIT is ignored.
- s_tready is never high outside LOAD/RD.
- Back-to-back compute commands must each pass through CLR, so the accumulator always starts at 0.
- The accumulator is not cleared by LOAD; loading B may interleave between computes.

Optional Feature:
- Macro PE_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT cycles elapse without pe_dvalid: err<=1 (sticky until the next accepted start), pe_aresetn pulsed low CLR_CYCLES, then FIN (done pulses, result unchanged).
- Undefined: no counter; WAIT is unbounded; err tied 0.

Decomposition:
- Package pe_seq_pkg holds:
  - FSM state enum (8 states, 3-bit).
  - Default constants CLR_CYCLES_DEF=2, TIMEOUT_DEF=64.
  - fp32 zero constant.
- No sub-module; the single FSM plus idx, clr and timeout counters stays within about 250 lines.

Test Plan:
- Behavioural PE model: 64-entry RAM, fixed 5-cycle FMA latency, accumulate on dvalid, clear on pe_aresetn low.
- Load 4 words 0x00400000 (fp16 2.0), then compute len=4 with A=0x003C0000 (fp16 1.0) -> result=0x41000000 (8.0), done one pulse; four pe_valid pulses, each 2 cycles after its A handshake.
- Run the same compute twice back-to-back -> both results 0x41000000; pe_aresetn low exactly 2 cycles before each.
- Compute with s_tvalid gapped randomly (0–7 idle cycles) -> result still 0x41000000; pe_valid count=4; no pe_valid while in WAIT.
- len=0 compute -> done on the cycle after start, result=0, no PE activity. len=127 load -> 64 writes, addr 0..63, then done.
- areset asserted in WAIT of element 2 -> next cycle IDLE, busy=0, pe_aresetn=0, no done. Restart -> correct 8.0.
- With PE_SEQ_TIMEOUT_EN, model never asserts dvalid -> err=1 and done after 64 WAIT cycles plus CLR. The next start clears err.
